// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter slice.
//   FRAME_BITS       : bit slots per 8N1 frame (start + 8 data + stop)
//   STATUS_EMPTY_BIT : position of the holding-register-empty flag in read data
//   shift_state_e    : shifter state encoding
package uart_pkg;

  localparam int FRAME_BITS       = 10;
  localparam int STATUS_EMPTY_BIT = 0;

  typedef enum logic {
    SH_IDLE  = 1'b0,
    SH_SHIFT = 1'b1
  } shift_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator for the UART transmitter.
//   clk_i     : system clock
//   rst_i     : synchronous active-high reset
//   restart_i : synchronous restart, counter returns to 0 at this edge
//   tick_o    : high for one cycle in the last cycle of each bit period
module uart_baud_gen #(
  parameter int BAUD_DIVIDER = 868
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = (BAUD_DIVIDER > 1) ? $clog2(BAUD_DIVIDER) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIVIDER - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a one-byte holding register.
//   clk, reset            : system clock, synchronous active-high reset
//   enable                : chip select from the address decoder
//   mem_valid/instr/wstrb : bus request (instr ignored; any wstrb bit = write)
//   mem_wdata/addr        : write data (byte in [7:0]); address not decoded
//   mem_ready             : one-cycle access acknowledge
//   mem_rdata             : read data {31'b0, empty}, zero outside read acks
//   serialOut             : registered TX line, idle high
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIVIDER = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        serialOut
);

  localparam logic [3:0] LAST_SLOT = 4'(FRAME_BITS - 1);

  logic         ready_q;
  logic [31:0]  rdata_q;
  logic         hold_full_q;
  logic         hold_full_d;
  logic [7:0]   hold_q;
  shift_state_e state_q;
  logic [3:0]   bit_cnt_q;
  logic [7:0]   shift_q;
  logic         line_q;

  logic         accept;
  logic         is_write;
  logic         tick;
  logic         frame_end;
  logic         load;
  logic [31:0]  status;
  logic         unused_inputs;

  assign unused_inputs = ^{mem_instr, mem_addr, mem_wdata[31:8]};

  // The ack pulse itself blocks acceptance, so a held request acks every other cycle.
  assign accept    = enable & mem_valid & ~ready_q;
  assign is_write  = |mem_wstrb;
  assign frame_end = (state_q == SH_SHIFT) && tick && (bit_cnt_q == LAST_SLOT);
  // Transfer needs a full holding register; a write only loads an empty one,
  // so the two can never target the holding register in the same cycle.
  assign load      = hold_full_q && ((state_q == SH_IDLE) || frame_end);

  always_comb begin
    status                   = '0;
    status[STATUS_EMPTY_BIT] = ~hold_full_q;
  end

  always_comb begin
    hold_full_d = hold_full_q;
    if (load) begin
      hold_full_d = 1'b0;
    end else if (accept && is_write) begin
      hold_full_d = 1'b1;
    end
  end

  uart_baud_gen #(
    .BAUD_DIVIDER(BAUD_DIVIDER)
  ) u_baud (
    .clk_i     (clk),
    .rst_i     (reset),
    .restart_i (load),
    .tick_o    (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      hold_full_q <= 1'b0;
    end else begin
      ready_q     <= accept;
      rdata_q     <= (accept && !is_write) ? status : '0;
      hold_full_q <= hold_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && is_write && !hold_full_q) begin
      hold_q <= mem_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      shift_q <= hold_q;
    end else if ((state_q == SH_SHIFT) && tick && (bit_cnt_q < 4'd8)) begin
      shift_q <= shift_q >> 1;
    end
  end

  // Slot 0 is the start bit, slots 1..8 data LSB first, slot 9 the stop bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SH_IDLE;
      bit_cnt_q <= '0;
      line_q    <= 1'b1;
    end else begin
      case (state_q)
        SH_IDLE: begin
          if (load) begin
            state_q   <= SH_SHIFT;
            bit_cnt_q <= '0;
            line_q    <= 1'b0;
          end
        end
        SH_SHIFT: begin
          if (tick) begin
            if (bit_cnt_q == LAST_SLOT) begin
              bit_cnt_q <= '0;
              if (load) begin
                line_q <= 1'b0;
              end else begin
                state_q <= SH_IDLE;
                line_q  <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              line_q    <= (bit_cnt_q < 4'd8) ? shift_q[0] : 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign serialOut = line_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int DIV = 10;
  localparam int FRAME_CYC = 10 * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mem_valid;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        serialOut;

  int errors = 0;
  int checks = 0;

  // Reference model: bus handshake, holding register, and a frame timeline
  // expressed as "cycles since frame start" over a 10-bit frame word.
  bit          m_ready;
  logic [31:0] m_rdata;
  bit          m_full;
  logic [7:0]  m_hold;
  bit          m_busy;
  int          m_pos;
  logic [9:0]  m_frame;

  // Line receiver: decodes frames from serialOut by mid-bit sampling.
  bit          rx_busy;
  int          rx_cnt;
  logic [7:0]  rx_byte;
  logic [7:0]  rx_q[$];

  uart_tx #(.BAUD_DIVIDER(DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .serialOut (serialOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit acc, wr, was_full;
    if (reset) begin
      m_ready = 0; m_rdata = '0; m_full = 0; m_busy = 0; m_pos = 0;
    end else begin
      acc      = enable && mem_valid && !m_ready;
      wr       = acc && (mem_wstrb != 4'b0);
      was_full = m_full;
      if (m_busy) begin
        if (m_pos == FRAME_CYC - 1) m_busy = 0;
        else m_pos++;
      end
      if (was_full && !m_busy) begin
        m_busy = 1; m_pos = 0; m_frame = {1'b1, m_hold, 1'b0}; m_full = 0;
      end
      if (wr && !was_full) begin
        m_full = 1; m_hold = mem_wdata[7:0];
      end
      m_ready = acc;
      m_rdata = (acc && !wr) ? {31'b0, !was_full} : 32'b0;
    end
  endtask

  task automatic rx_step();
    if (!rx_busy) begin
      if (serialOut === 1'b0) begin
        rx_busy = 1; rx_cnt = 0; rx_byte = '0;
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt % DIV == DIV / 2) && (rx_cnt < 9 * DIV))
        rx_byte[rx_cnt / DIV - 1] = serialOut;
      if (rx_cnt == 9 * DIV + DIV / 2) begin
        check("rx_stop_bit", {31'b0, serialOut}, 32'd1);
        rx_q.push_back(rx_byte);
        rx_busy = 0;
      end
    end
  endtask

  // One clock: model follows the inputs present at the edge, outputs compared #1 after.
  task automatic tick();
    logic exp_line;
    @(posedge clk);
    #1;
    model_step();
    exp_line = m_busy ? m_frame[m_pos / DIV] : 1'b1;
    check("serialOut", {31'b0, serialOut}, {31'b0, exp_line});
    check("mem_ready", {31'b0, mem_ready}, {31'b0, m_ready});
    check("mem_rdata", mem_rdata, m_rdata);
    rx_step();
  endtask

  task automatic idle_inputs();
    enable = 0; mem_valid = 0; mem_instr = 0; mem_wstrb = '0; mem_wdata = '0; mem_addr = '0;
  endtask

  task automatic bus_op(input bit wr, input logic [7:0] data, output logic [31:0] rd);
    bit got = 0;
    rd        = '0;
    enable    = 1;
    mem_valid = 1;
    mem_wstrb = wr ? 4'($urandom_range(1, 15)) : 4'b0;
    mem_wdata = ($urandom() << 8) | {24'b0, data};
    mem_addr  = $urandom();
    mem_instr = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if (mem_ready === 1'b1) begin
        got = 1; rd = mem_rdata;
      end
    end
    idle_inputs();
    check("bus_ack_seen", {31'b0, got}, 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (!m_busy && !m_full && !rx_busy) done = 1;
      else tick();
    end
    check("wait_idle", {31'b0, done}, 32'd1);
  endtask

  task automatic check_rx(input string tag, input logic [7:0] exp[$]);
    check({tag, "_count"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      check({tag, "_byte"}, {24'b0, rx_q[i]}, {24'b0, exp[i]});
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  exp_bytes[$];
    logic [7:0]  b;
    int          acks;
    bit          found;

    idle_inputs();
    reset = 1;
    rx_busy = 0;

    // Reset for two cycles
    repeat (2) tick();
    check("rst_serialOut", {31'b0, serialOut}, 32'd1);
    check("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    reset = 0;
    tick();
    check("idle_status_read_pre", {31'b0, m_full}, 32'd0);
    bus_op(0, 8'h00, rd);
    check("idle_status_read", rd, 32'd1);

    // Single frame 0xAA
    rx_q.delete();
    bus_op(1, 8'hAA, rd);
    check("first_start_bit", {31'b0, serialOut}, 32'd1);
    tick();
    check("start_bit_after_ack", {31'b0, serialOut}, 32'd0);
    wait_idle();
    exp_bytes = '{8'hAA};
    check_rx("frame_AA", exp_bytes);

    // Read right after write, then a second write and read
    rx_q.delete();
    bus_op(1, 8'hAA, rd);
    bus_op(0, 8'h00, rd);
    check("read_after_write", rd, 32'h1);
    bus_op(1, 8'h55, rd);
    bus_op(0, 8'h00, rd);
    check("read_when_full", rd, 32'h0);
    wait_idle();
    exp_bytes = '{8'hAA, 8'h55};
    check_rx("frames_AA_55", exp_bytes);

    // Polled streaming
    rx_q.delete();
    exp_bytes = '{8'hAA, 8'h55};
    for (int k = 0; k < 3; k++) exp_bytes.push_back(8'($urandom()));
    foreach (exp_bytes[k]) begin
      found = 0;
      for (int p = 0; p < 200 && !found; p++) begin
        bus_op(0, 8'h00, rd);
        if (rd[0] === 1'b1) found = 1;
      end
      check("poll_empty_seen", {31'b0, found}, 32'd1);
      bus_op(1, exp_bytes[k], rd);
    end
    wait_idle();
    check_rx("poll_stream", exp_bytes);

    // Overflowing the holding register drops the third byte
    rx_q.delete();
    bus_op(1, 8'h11, rd);
    bus_op(1, 8'h22, rd);
    bus_op(1, 8'h33, rd);
    wait_idle();
    exp_bytes = '{8'h11, 8'h22};
    check_rx("overflow_drop", exp_bytes);

    // Request held continuously acks every second cycle
    acks = 0;
    enable = 1; mem_valid = 1; mem_wstrb = 4'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_ready === 1'b1) acks++;
    end
    idle_inputs();
    check("held_request_acks", acks, 32'd4);
    tick();

    // Randomized bus traffic against the model
    for (int i = 0; i < 1500; i++) begin
      enable    = ($urandom_range(0, 3) != 0);
      mem_valid = 1'($urandom_range(0, 1));
      mem_wstrb = ($urandom_range(0, 1) != 0) ? 4'($urandom()) : 4'b0;
      mem_wdata = $urandom();
      mem_addr  = $urandom();
      mem_instr = 1'($urandom_range(0, 1));
      tick();
    end
    idle_inputs();
    wait_idle();

    // Reset in the middle of a frame
    rx_q.delete();
    b = 8'($urandom());
    bus_op(1, b, rd);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_busy && m_pos == 4 * DIV + 3) found = 1;
      else tick();
    end
    check("reached_bit4", {31'b0, found}, 32'd1);
    reset = 1;
    tick();
    check("reset_mid_frame_line", {31'b0, serialOut}, 32'd1);
    reset = 0;
    rx_busy = 0;
    rx_q.delete();
    bus_op(0, 8'h00, rd);
    check("reset_mid_frame_empty", rd, 32'h1);
    repeat (150) tick();
    check("no_frame_after_reset", rx_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
